// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state encoding, screen defaults and packed-bus slice helper
package sprite_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SELECT, S_ERASE, S_DRAW, S_FIN} state_t;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_BG_COLOUR = 0;
  localparam int BUS_MAX = 1024;
  function automatic logic [31:0] slice(input logic [BUS_MAX-1:0] bus, input int i, input int w);
    logic [BUS_MAX-1:0] s;
    s = bus >> (i * w);
    return s[31:0] & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/sprite_scan.sv
// sprite_scan: pixel walker over one sprite footprint with clip and mask decode
module sprite_scan #(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [SPR_W*SPR_H-1:0] SPR_MASK = '1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py,
  output logic           hit,
  output logic           last
);
  localparam int P = SPR_W * SPR_H;
  localparam int PW = P > 1 ? $clog2(P) : 1;
  localparam int DXW = SPR_W > 1 ? $clog2(SPR_W) : 1;
  localparam int DYW = SPR_H > 1 ? $clog2(SPR_H) : 1;
  logic [PW-1:0] p;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic [X_W:0] wx;
  logic [Y_W:0] wy;
  logic dx_last;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      p <= '0;
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      p <= last ? '0 : p + PW'(1);
      dx <= dx_last ? '0 : dx + DXW'(1);
      dy <= last ? '0 : dx_last ? dy + DYW'(1) : dy;
    end
  always_comb begin
    dx_last = dx == DXW'(SPR_W - 1);
    last = dx_last && dy == DYW'(SPR_H - 1);
    wx = {1'b0, base_x} + (X_W+1)'(dx);
    wy = {1'b0, base_y} + (Y_W+1)'(dy);
    px = wx[X_W-1:0];
    py = wy[Y_W-1:0];
    hit = wx < (X_W+1)'(SCREEN_W) && wy < (Y_W+1)'(SCREEN_H) && SPR_MASK[p];
  end
endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: erases and redraws up to N_SPRITES sprites into the frame buffer per start
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 10,
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(DEF_BG_COLOUR),
  parameter logic [SPR_W*SPR_H-1:0] SPR_MASK = '1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            erase_en,
  input  logic [N_SPRITES*X_W-1:0]        pos_x,
  input  logic [N_SPRITES*Y_W-1:0]        pos_y,
  input  logic [N_SPRITES-1:0]            visible,
  input  logic [N_SPRITES*COLOUR_W-1:0]   spr_colour,
  output logic                            busy,
  output logic                            done,
  output logic [X_W-1:0]                  x_out,
  output logic [Y_W-1:0]                  y_out,
  output logic [COLOUR_W-1:0]             colour_out,
  output logic                            plot
);
  localparam int IW = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic er, ers, act, hit, last, ovis, nvis;
  logic [N_SPRITES*X_W-1:0] new_x, old_x;
  logic [N_SPRITES*Y_W-1:0] new_y, old_y;
  logic [N_SPRITES-1:0] new_vis, old_vis;
  logic [N_SPRITES*COLOUR_W-1:0] new_col;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  state_t adv;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      er <= 1'b0;
      new_x <= '0;
      new_y <= '0;
      new_vis <= '0;
      new_col <= '0;
      old_x <= '0;
      old_y <= '0;
      old_vis <= '0;
    end else begin
      idx <= state == S_LATCH ? '0 : nxt == S_SELECT ? idx + IW'(1) : idx;
      if (state == S_LATCH) begin
        er <= erase_en;
        new_x <= pos_x;
        new_y <= pos_y;
        new_vis <= visible;
        new_col <= spr_colour;
      end
      if (state == S_FIN) begin
        old_x <= new_x;
        old_y <= new_y;
        old_vis <= new_vis;
      end
    end
  always_comb begin
    ers = state == S_ERASE;
    act = ers || state == S_DRAW;
    ovis = old_vis[idx];
    nvis = new_vis[idx];
    adv = idx == IW'(N_SPRITES - 1) ? S_FIN : S_SELECT;
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? S_LATCH : S_IDLE;
      S_LATCH:  nxt = S_SELECT;
      S_SELECT: nxt = ovis && er ? S_ERASE : nvis ? S_DRAW : adv;
      S_ERASE:  nxt = !last ? S_ERASE : nvis ? S_DRAW : adv;
      S_DRAW:   nxt = last ? adv : S_DRAW;
      default:  nxt = S_IDLE;
    endcase
    base_x = X_W'(slice(BUS_MAX'(ers ? old_x : new_x), int'(idx), X_W));
    base_y = Y_W'(slice(BUS_MAX'(ers ? old_y : new_y), int'(idx), Y_W));
    colour_out = ers ? BG_COLOUR : COLOUR_W'(slice(BUS_MAX'(new_col), int'(idx), COLOUR_W));
    busy = state != S_IDLE;
    done = state == S_FIN;
    plot = act && hit;
  end
  sprite_scan #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .X_W(X_W), .Y_W(Y_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .SPR_MASK(SPR_MASK)
  ) u_scan (
    .clk(clk), .reset_n(reset_n), .en(act), .base_x(base_x), .base_y(base_y),
    .px(x_out), .py(y_out), .hit(hit), .last(last)
  );
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: scoreboard bench for full-mask and 6996-mask plotters
module tb_sprite_plotter;
  localparam int N = 10;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  logic clk = 0, reset_n = 0, start = 0, erase_en = 0;
  logic [N*8-1:0] pos_x = '0;
  logic [N*7-1:0] pos_y = '0;
  logic [N-1:0] visible = '0;
  logic [N*3-1:0] spr_colour = '0;
  logic busy, done, plot, busy_m, done_m, plot_m;
  logic [7:0] x_out, x_m;
  logic [6:0] y_out, y_m;
  logic [2:0] colour_out, c_m;
  pix_t q0[$], q1[$];
  pix_t e0, e1;
  logic [7:0] ox[N];
  logic [6:0] oy[N];
  logic ov[N];
  int total = 0, bad = 0;

  sprite_plotter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .erase_en(erase_en),
    .pos_x(pos_x), .pos_y(pos_y), .visible(visible), .spr_colour(spr_colour),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );
  sprite_plotter #(.SPR_MASK(16'h6996)) dut_m (
    .clk(clk), .reset_n(reset_n), .start(start), .erase_en(erase_en),
    .pos_x(pos_x), .pos_y(pos_y), .visible(visible), .spr_colour(spr_colour),
    .busy(busy_m), .done(done_m), .x_out(x_m), .y_out(y_m),
    .colour_out(c_m), .plot(plot_m)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && plot) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL plot_full unexpected x=%0d y=%0d c=%0d", x_out, y_out, colour_out);
      end else begin
        e0 = q0.pop_front();
        if ({x_out, y_out, colour_out} !== e0) begin
          bad++;
          $display("FAIL plot_full got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   x_out, y_out, colour_out, e0.x, e0.y, e0.c);
        end
      end
    end
    if (reset_n && plot_m) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL plot_mask unexpected x=%0d y=%0d c=%0d", x_m, y_m, c_m);
      end else begin
        e1 = q1.pop_front();
        if ({x_m, y_m, c_m} !== e1) begin
          bad++;
          $display("FAIL plot_mask got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   x_m, y_m, c_m, e1.x, e1.y, e1.c);
        end
      end
    end
  end

  task automatic push_spr(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    logic [15:0] mm;
    int ax, ay, pp;
    mm = 16'h6996;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        ax = int'(x) + dx;
        ay = int'(y) + dy;
        pp = dy * 4 + dx;
        if (ax < 160 && ay < 120) begin
          q0.push_back({8'(ax), 7'(ay), c});
          if (mm[pp]) q1.push_back({8'(ax), 7'(ay), c});
        end
      end
  endtask

  task automatic expect_pass(input logic er, output int len);
    int ph;
    ph = 0;
    for (int i = 0; i < N; i++) begin
      if (ov[i] && er) begin
        push_spr(ox[i], oy[i], 3'd0);
        ph++;
      end
      if (visible[i]) begin
        push_spr(pos_x[i*8 +: 8], pos_y[i*7 +: 7], spr_colour[i*3 +: 3]);
        ph++;
      end
      ox[i] = pos_x[i*8 +: 8];
      oy[i] = pos_y[i*7 +: 7];
      ov[i] = visible[i];
    end
    len = 2 + N + 16 * ph;
  endtask

  task automatic set_spr(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic v, input logic [2:0] c);
    pos_x[i*8 +: 8] = x;
    pos_y[i*7 +: 7] = y;
    visible[i] = v;
    spr_colour[i*3 +: 3] = c;
  endtask

  task automatic run_pass(input logic er, input string nm);
    int len, cnt, dcyc;
    logic [N*8-1:0] sx;
    logic [N*7-1:0] sy;
    logic [N-1:0] sv;
    logic [N*3-1:0] sc;
    expect_pass(er, len);
    sx = pos_x; sy = pos_y; sv = visible; sc = spr_colour;
    @(negedge clk);
    start = 1;
    erase_en = er;
    @(negedge clk);
    start = 0;
    cnt = 0;
    dcyc = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      if (done) dcyc = cnt;
      if (cnt == 2) begin
        for (int i = 0; i < N; i++) begin
          pos_x[i*8 +: 8] = 8'($urandom);
          pos_y[i*7 +: 7] = 7'($urandom);
          spr_colour[i*3 +: 3] = 3'($urandom);
        end
        visible = N'($urandom);
        erase_en = ~er;
      end
      if (cnt == 5) start = 1;
      if (cnt == 7) start = 0;
      @(negedge clk);
    end
    pos_x = sx; pos_y = sy; visible = sv; spr_colour = sc;
    total++;
    if (cnt !== len) begin bad++; $display("FAIL %s_len got=%0d want=%0d", nm, cnt, len); end
    total++;
    if (dcyc !== len) begin bad++; $display("FAIL %s_done got=%0d want=%0d", nm, dcyc, len); end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got=%0d/%0d want=0/0", nm, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
    total++;
    if ({busy, done, busy_m} !== 3'b000) begin
      bad++;
      $display("FAIL %s_idle got=%b want=000", nm, {busy, done, busy_m});
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++) ov[i] = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, plot} !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b want=000", {busy, done, plot}); end
    total++;
    if (x_out !== 8'd0) begin bad++; $display("FAIL rst_x got=%0d want=0", x_out); end
    total++;
    if (y_out !== 7'd0) begin bad++; $display("FAIL rst_y got=%0d want=0", y_out); end
    total++;
    if (colour_out !== 3'd0) begin bad++; $display("FAIL rst_c got=%0d want=0", colour_out); end
    total++;
    if ({busy_m, done_m, plot_m} !== 3'b000) begin bad++; $display("FAIL rst_m got=%b want=000", {busy_m, done_m, plot_m}); end
    reset_n = 1;
    @(negedge clk);
    total++;
    if ({busy, plot} !== 2'b00) begin bad++; $display("FAIL rst_rel got=%b want=00", {busy, plot}); end
  endtask

  task automatic test_empty;
    run_pass(1'b1, "empty");
  endtask

  task automatic test_single;
    set_spr(0, 8'd10, 7'd20, 1'b1, 3'b100);
    run_pass(1'b1, "first");
  endtask

  task automatic test_move;
    set_spr(0, 8'd11, 7'd20, 1'b1, 3'b100);
    run_pass(1'b1, "move_erase");
    set_spr(0, 8'd12, 7'd20, 1'b1, 3'b010);
    run_pass(1'b0, "move_trail");
  endtask

  task automatic test_clip;
    set_spr(0, 8'd158, 7'd118, 1'b1, 3'd5);
    set_spr(5, 8'd157, 7'd60, 1'b1, 3'd2);
    run_pass(1'b0, "clip");
    set_spr(5, 8'd157, 7'd60, 1'b0, 3'd2);
  endtask

  task automatic test_back_to_back;
    int l1, l2, cnt;
    set_spr(0, 8'd30, 7'd40, 1'b1, 3'd1);
    set_spr(3, 8'd0, 7'd0, 1'b1, 3'd7);
    expect_pass(1'b1, l1);
    expect_pass(1'b1, l2);
    @(negedge clk);
    start = 1;
    erase_en = 1;
    @(negedge clk);
    cnt = 0;
    while (busy && cnt < 5000) begin cnt++; @(negedge clk); end
    total++;
    if (cnt !== l1) begin bad++; $display("FAIL b2b_len1 got=%0d want=%0d", cnt, l1); end
    @(negedge clk);
    start = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_retrigger got=%b want=1", busy); end
    cnt = 0;
    while (busy && cnt < 5000) begin cnt++; @(negedge clk); end
    total++;
    if (cnt !== l2) begin bad++; $display("FAIL b2b_len2 got=%0d want=%0d", cnt, l2); end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing got=%0d/%0d want=0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    set_spr(3, 8'd0, 7'd0, 1'b0, 3'd7);
    run_pass(1'b1, "b2b_cleanup");
  endtask

  task automatic test_reset_mid;
    int len, cnt;
    set_spr(0, 8'd40, 7'd30, 1'b1, 3'd6);
    expect_pass(1'b1, len);
    @(negedge clk);
    start = 1;
    erase_en = 1;
    @(negedge clk);
    start = 0;
    cnt = 1;
    while (cnt < 24) begin @(negedge clk); cnt++; end
    total++;
    if (plot !== 1'b1) begin bad++; $display("FAIL rmid_drawing got=%b want=1", plot); end
    #2 reset_n = 0;
    #1;
    total++;
    if ({plot, busy, done} !== 3'b000) begin bad++; $display("FAIL rmid_full got=%b want=000", {plot, busy, done}); end
    total++;
    if ({plot_m, busy_m} !== 2'b00) begin bad++; $display("FAIL rmid_mask got=%b want=00", {plot_m, busy_m}); end
    q0.delete();
    q1.delete();
    for (int i = 0; i < N; i++) ov[i] = 0;
    @(negedge clk);
    reset_n = 1;
    run_pass(1'b1, "after_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_move();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
